// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Time-shares one cartridge PSRAM between three byte requesters:
//     - SNES bus (ROM / SaveRAM), 1-cycle strobe, latched internally
//     - MCU, level request held until mcu_rdy
//     - DCU (SPC7110 decompression / data-ROM), read-only level request
//   One access at a time: IDLE -> ACCESS (ACC_CYCLES) -> RECOVER (REC_CYCLES)
//   -> IDLE. SNES always wins arbitration; DCU outranks MCU until MCU has
//   watched MCU_STARVE DCU grants go by, then MCU outranks DCU once.
//   SNES writes with snes_wrok=0 are executed as reads (SaveRAM protection).
//
//   Configuration macro: PSRAM_ARB_DCU_EN
//     defined   : DCU port arbitrated, starve counter present
//     undefined : dcu_req ignored, dcu_rdy/dcu_rdata tied low, fixed SNES > MCU
//
// Ports
//   CLK, RST_N                 clock, async active-low reset
//   snes_req/we/addr/wrok/wdata SNES strobe request and write data
//   snes_rdata, snes_rdy       SNES read data + 1-cycle completion
//   mcu_req/we/addr/wdata      MCU level request
//   mcu_rdata, mcu_rdy         MCU read data + 1-cycle completion
//   dcu_req/addr               DCU level read request
//   dcu_rdata, dcu_rdy         DCU read data + 1-cycle completion
//   ram_addr/wdata/rdata       PSRAM data path
//   ram_oe_n, ram_we_n         PSRAM strobes, active low
module psram_arbiter #(
  parameter int unsigned ACC_CYCLES = 6,
  parameter int unsigned REC_CYCLES = 1,
  parameter int unsigned MCU_STARVE = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        snes_req,
  input  logic        snes_we,
  input  logic [23:0] snes_addr,
  input  logic        snes_wrok,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_rdy,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_rdy,
  input  logic        dcu_req,
  input  logic [23:0] dcu_addr,
  output logic [7:0]  dcu_rdata,
  output logic        dcu_rdy,
  output logic [23:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
  typedef enum logic [1:0] {OWN_SNES, OWN_MCU, OWN_DCU} owner_t;

  localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES);
  localparam logic [1:0] REC_LOAD = 2'(REC_CYCLES);

  state_t      state;
  owner_t      owner;
  logic [3:0]  acc_cnt;
  logic [1:0]  rec_cnt;

  // Latched SNES request
  logic        snes_pend;
  logic        snes_pwe;
  logic        snes_pwrok;
  logic [23:0] snes_paddr;
  logic [7:0]  snes_pwdata;

  // Arbitration result (meaningful in S_IDLE only)
  logic        gnt_any;
  owner_t      gnt_owner;
  logic [23:0] gnt_addr;
  logic [7:0]  gnt_wdata;
  logic        gnt_write;
  logic        grant;

  logic        dcu_active;
  logic        mcu_over_dcu;

`ifdef PSRAM_ARB_DCU_EN
  localparam logic [2:0] STARVE_MAX = 3'(MCU_STARVE);
  logic [2:0] starve_cnt;

  assign dcu_active   = dcu_req;
  assign mcu_over_dcu = (starve_cnt == STARVE_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else if (!mcu_req) begin
      starve_cnt <= '0;
    end else if (grant && gnt_owner == OWN_MCU) begin
      starve_cnt <= '0;
    end else if (grant && gnt_owner == OWN_DCU && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  logic unused_dcu;
  assign unused_dcu   = ^{dcu_req, dcu_addr};
  assign dcu_active   = 1'b0;
  assign mcu_over_dcu = 1'b1;
  assign dcu_rdata    = '0;
  assign dcu_rdy      = 1'b0;
`endif

  // A same-cycle SNES strobe takes precedence over the latch so the newest
  // SNES request is served and no second completion is generated.
  always_comb begin
    gnt_any   = 1'b1;
    gnt_owner = OWN_SNES;
    gnt_addr  = snes_req ? snes_addr  : snes_paddr;
    gnt_wdata = snes_req ? snes_wdata : snes_pwdata;
    gnt_write = snes_req ? (snes_we & snes_wrok) : (snes_pwe & snes_pwrok);
    if (snes_req || snes_pend) begin
      gnt_owner = OWN_SNES;
    end else if (mcu_req && (mcu_over_dcu || !dcu_active)) begin
      gnt_owner = OWN_MCU;
      gnt_addr  = mcu_addr;
      gnt_wdata = mcu_wdata;
      gnt_write = mcu_we;
    end else if (dcu_active) begin
      gnt_owner = OWN_DCU;
      gnt_addr  = dcu_addr;
      gnt_wdata = '0;
      gnt_write = 1'b0;
    end else begin
      gnt_any   = 1'b0;
    end
  end

  assign grant = (state == S_IDLE) && gnt_any;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      owner       <= OWN_SNES;
      acc_cnt     <= '0;
      rec_cnt     <= '0;
      snes_pend   <= 1'b0;
      snes_pwe    <= 1'b0;
      snes_pwrok  <= 1'b0;
      snes_paddr  <= '0;
      snes_pwdata <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      snes_rdata  <= '0;
      snes_rdy    <= 1'b0;
      mcu_rdata   <= '0;
      mcu_rdy     <= 1'b0;
`ifdef PSRAM_ARB_DCU_EN
      dcu_rdata   <= '0;
      dcu_rdy     <= 1'b0;
`endif
    end else begin
      snes_rdy <= 1'b0;
      mcu_rdy  <= 1'b0;
`ifdef PSRAM_ARB_DCU_EN
      dcu_rdy  <= 1'b0;
`endif
      if (snes_req) begin
        snes_pend   <= 1'b1;
        snes_pwe    <= snes_we;
        snes_pwrok  <= snes_wrok;
        snes_paddr  <= snes_addr;
        snes_pwdata <= snes_wdata;
      end

      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_owner;
            ram_addr  <= gnt_addr;
            ram_wdata <= gnt_wdata;
            ram_oe_n  <= gnt_write;
            ram_we_n  <= ~gnt_write;
            acc_cnt   <= ACC_LOAD;
            state     <= S_ACCESS;
            // Overrides the capture above: a same-cycle strobe is consumed here.
            if (gnt_owner == OWN_SNES) snes_pend <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (acc_cnt == 4'd1) begin
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            case (owner)
              OWN_SNES: begin
                snes_rdata <= ram_rdata;
                snes_rdy   <= 1'b1;
              end
              OWN_MCU: begin
                mcu_rdata <= ram_rdata;
                mcu_rdy   <= 1'b1;
              end
`ifdef PSRAM_ARB_DCU_EN
              OWN_DCU: begin
                dcu_rdata <= ram_rdata;
                dcu_rdy   <= 1'b1;
              end
`endif
              default: ;
            endcase
            if (REC_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              rec_cnt <= REC_LOAD;
              state   <= S_RECOVER;
            end
          end else begin
            acc_cnt <= acc_cnt - 4'd1;
          end
        end
        S_RECOVER: begin
          if (rec_cnt <= 2'd1) state <= S_IDLE;
          else rec_cnt <= rec_cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter with a behavioural PSRAM
// (4 KiB, indexed by ram_addr[11:0]). Inputs driven and outputs sampled on
// the falling clock edge.
module tb_psram_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        snes_req = 1'b0, snes_we = 1'b0, snes_wrok = 1'b0;
  logic [23:0] snes_addr = '0;
  logic [7:0]  snes_wdata = '0;
  logic [7:0]  snes_rdata;
  logic        snes_rdy;
  logic        mcu_req = 1'b0, mcu_we = 1'b0;
  logic [23:0] mcu_addr = '0;
  logic [7:0]  mcu_wdata = '0;
  logic [7:0]  mcu_rdata;
  logic        mcu_rdy;
  logic        dcu_req = 1'b0;
  logic [23:0] dcu_addr = '0;
  logic [7:0]  dcu_rdata;
  logic        dcu_rdy;
  logic [23:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_oe_n, ram_we_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!ram_we_n) mem[ram_addr[11:0]] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr[11:0]];

  psram_arbiter #(.ACC_CYCLES(6), .REC_CYCLES(1), .MCU_STARVE(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr),
    .snes_wrok(snes_wrok), .snes_wdata(snes_wdata),
    .snes_rdata(snes_rdata), .snes_rdy(snes_rdy),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr),
    .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_rdy(mcu_rdy),
    .dcu_req(dcu_req), .dcu_addr(dcu_addr),
    .dcu_rdata(dcu_rdata), .dcu_rdy(dcu_rdy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge CLK); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK); pre_we = 1'b0;
  endtask

  // Issue a one-cycle SNES strobe; returns at the negedge after the strobe edge.
  task automatic snes_strobe(input logic we, input logic wrok,
                             input logic [23:0] a, input logic [7:0] d);
    @(negedge CLK);
    snes_req = 1'b1; snes_we = we; snes_wrok = wrok; snes_addr = a; snes_wdata = d;
    @(negedge CLK);
    snes_req = 1'b0;
  endtask

  // Observe n falling edges starting with the current one.
  task automatic observe(input int n, output int oe_low, output int we_low,
                         output int s_cnt, output int s_at, output logic [7:0] s_data,
                         output int m_cnt, output int d_cnt, output int bad_addr,
                         input logic [23:0] exp_addr);
    oe_low = 0; we_low = 0; s_cnt = 0; s_at = -1; s_data = '0;
    m_cnt = 0; d_cnt = 0; bad_addr = 0;
    for (int i = 0; i < n; i++) begin
      if (!ram_oe_n) oe_low++;
      if (!ram_we_n) we_low++;
      if ((!ram_oe_n || !ram_we_n) && ram_addr !== exp_addr) bad_addr++;
      if (snes_rdy) begin s_cnt++; s_at = i; s_data = snes_rdata; end
      if (mcu_rdy) m_cnt++;
      if (dcu_rdy) d_cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    n_checks++;
    if ({ram_oe_n, ram_we_n} !== 2'b11) begin
      $display("FAIL reset_strobes got %b exp 11", {ram_oe_n, ram_we_n}); n_fail++;
    end
    n_checks++;
    if (ram_addr !== 24'h0 || ram_wdata !== 8'h0) begin
      $display("FAIL reset_ram_bus got %h/%h exp 000000/00", ram_addr, ram_wdata); n_fail++;
    end
    n_checks++;
    if ({snes_rdy, mcu_rdy, dcu_rdy} !== 3'b000) begin
      $display("FAIL reset_rdy got %b exp 000", {snes_rdy, mcu_rdy, dcu_rdy}); n_fail++;
    end
    n_checks++;
    if (snes_rdata !== 8'h0 || mcu_rdata !== 8'h0 || dcu_rdata !== 8'h0) begin
      $display("FAIL reset_rdata got %h %h %h exp 00 00 00", snes_rdata, mcu_rdata, dcu_rdata);
      n_fail++;
    end
    RST_N = 1'b1;
  endtask

  task automatic test_snes_read;
    int oe, we, sc, sa, mc, dc, ba;
    logic [7:0] sd;
    preload(12'h123, 8'h5A);
    snes_strobe(1'b0, 1'b0, 24'h000123, 8'h00);
    observe(12, oe, we, sc, sa, sd, mc, dc, ba, 24'h000123);
    n_checks++;
    if (oe != 6 || we != 0) begin
      $display("FAIL snes_read_strobes got oe=%0d we=%0d exp oe=6 we=0", oe, we); n_fail++;
    end
    n_checks++;
    if (ba != 0) begin
      $display("FAIL snes_read_addr got %0d bad cycles exp 0", ba); n_fail++;
    end
    n_checks++;
    if (sc != 1 || sa != 6) begin
      $display("FAIL snes_read_rdy got count=%0d at=%0d exp count=1 at=6", sc, sa); n_fail++;
    end
    n_checks++;
    if (sd !== 8'h5A) begin
      $display("FAIL snes_read_data got %h exp 5a", sd); n_fail++;
    end
  endtask

  task automatic test_snes_write;
    int oe, we, sc, sa, mc, dc, ba;
    logic [7:0] sd;
    preload(12'h010, 8'h00);
    snes_strobe(1'b1, 1'b1, 24'hE00010, 8'hA5);
    observe(12, oe, we, sc, sa, sd, mc, dc, ba, 24'hE00010);
    n_checks++;
    if (we != 6 || oe != 0) begin
      $display("FAIL snes_write_strobes got oe=%0d we=%0d exp oe=0 we=6", oe, we); n_fail++;
    end
    n_checks++;
    if (mem[12'h010] !== 8'hA5 || sc != 1) begin
      $display("FAIL snes_write_mem got %h rdy=%0d exp a5 rdy=1", mem[12'h010], sc); n_fail++;
    end
    // Write-protected: becomes a read, RAM untouched.
    snes_strobe(1'b1, 1'b0, 24'hE00010, 8'h3C);
    observe(12, oe, we, sc, sa, sd, mc, dc, ba, 24'hE00010);
    n_checks++;
    if (we != 0 || oe != 6) begin
      $display("FAIL snes_wprot_strobes got oe=%0d we=%0d exp oe=6 we=0", oe, we); n_fail++;
    end
    n_checks++;
    if (mem[12'h010] !== 8'hA5 || sc != 1 || sd !== 8'hA5) begin
      $display("FAIL snes_wprot_result got mem=%h rdy=%0d data=%h exp a5 1 a5",
               mem[12'h010], sc, sd);
      n_fail++;
    end
  endtask

  task automatic test_snes_during_mcu;
    int m_at = -1, s_at = -1, m_cnt = 0, s_cnt = 0;
    logic [7:0] md = '0, sd = '0;
    preload(12'h200, 8'h77);
    preload(12'h201, 8'h99);
    @(negedge CLK); mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000200;
    @(negedge CLK);                                  // access cycle 1
    @(negedge CLK);                                  // access cycle 2
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h000201;
    @(negedge CLK); snes_req = 1'b0;                 // strobe sampled, t = 0
    for (int t = 1; t <= 16; t++) begin
      @(negedge CLK);
      if (mcu_rdy) begin m_at = t; m_cnt++; md = mcu_rdata; mcu_req = 1'b0; end
      if (snes_rdy) begin s_at = t; s_cnt++; sd = snes_rdata; end
    end
    mcu_req = 1'b0;
    n_checks++;
    if (m_at != 4 || m_cnt != 1 || md !== 8'h77) begin
      $display("FAIL mcu_read got at=%0d cnt=%0d data=%h exp at=4 cnt=1 data=77", m_at, m_cnt, md);
      n_fail++;
    end
    n_checks++;
    if (s_at != 12 || s_cnt != 1 || sd !== 8'h99) begin
      $display("FAIL snes_after_mcu got at=%0d cnt=%0d data=%h exp at=12 cnt=1 data=99",
               s_at, s_cnt, sd);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_access;
    int oe, we, sc, sa, mc, dc, ba;
    logic [7:0] sd;
    preload(12'h123, 8'h5A);
    @(negedge CLK); mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000400;
    @(negedge CLK);
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h000123;
    @(negedge CLK); snes_req = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ram_oe_n !== 1'b0) begin
      $display("FAIL mid_access_active got oe_n=%b exp 0", ram_oe_n); n_fail++;
    end
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (ram_oe_n !== 1'b1) begin
      $display("FAIL reset_abort_oe got oe_n=%b exp 1", ram_oe_n); n_fail++;
    end
    @(negedge CLK); mcu_req = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    observe(16, oe, we, sc, sa, sd, mc, dc, ba, 24'h0);
    n_checks++;
    if (oe != 0 || we != 0 || sc != 0 || mc != 0) begin
      $display("FAIL reset_abort_quiet got oe=%0d we=%0d snes=%0d mcu=%0d exp 0 0 0 0",
               oe, we, sc, mc);
      n_fail++;
    end
    snes_strobe(1'b0, 1'b0, 24'h000123, 8'h00);
    observe(12, oe, we, sc, sa, sd, mc, dc, ba, 24'h000123);
    n_checks++;
    if (sc != 1 || sa != 6 || sd !== 8'h5A) begin
      $display("FAIL post_reset_read got cnt=%0d at=%0d data=%h exp 1 6 5a", sc, sa, sd);
      n_fail++;
    end
  endtask

`ifdef PSRAM_ARB_DCU_EN
  task automatic test_back_to_back;
    logic is_mcu [0:9];
    int k = 0;
    preload(12'h300, 8'h11);
    preload(12'h301, 8'h22);
    @(negedge CLK);
    dcu_req = 1'b1; dcu_addr = 24'h000300;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000301;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge CLK);
      if (dcu_rdy || mcu_rdy) begin
        is_mcu[k] = mcu_rdy;
        n_checks++;
        if (dcu_rdy && mcu_rdy) begin
          $display("FAIL b2b_both_rdy at completion %0d", k); n_fail++;
        end else if (mcu_rdy && mcu_rdata !== 8'h22) begin
          $display("FAIL b2b_mcu_data got %h exp 22", mcu_rdata); n_fail++;
        end else if (dcu_rdy && dcu_rdata !== 8'h11) begin
          $display("FAIL b2b_dcu_data got %h exp 11", dcu_rdata); n_fail++;
        end
        k++;
      end
    end
    dcu_req = 1'b0; mcu_req = 1'b0;
    n_checks++;
    if (k != 10) begin
      $display("FAIL b2b_timeout got %0d completions exp 10", k); n_fail++;
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (is_mcu[i] !== (i % 5 == 4)) begin
        $display("FAIL b2b_order slot %0d got mcu=%b exp %b", i, is_mcu[i], (i % 5 == 4));
        n_fail++;
      end
    end
    repeat (10) @(negedge CLK);
  endtask
`else
  task automatic test_dcu_disabled;
    int oe, we, sc, sa, mc, dc, ba;
    logic [7:0] sd;
    preload(12'h300, 8'h11);
    @(negedge CLK); dcu_req = 1'b1; dcu_addr = 24'h000300;
    observe(30, oe, we, sc, sa, sd, mc, dc, ba, 24'h0);
    n_checks++;
    if (oe != 0 || dc != 0 || dcu_rdata !== 8'h00) begin
      $display("FAIL dcu_ignored got oe=%0d rdy=%0d data=%h exp 0 0 00", oe, dc, dcu_rdata);
      n_fail++;
    end
    @(negedge CLK); mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 24'h000302; mcu_wdata = 8'h6E;
    for (int c = 0; c < 20 && !mcu_rdy; c++) @(negedge CLK);
    mcu_req = 1'b0;
    n_checks++;
    if (mcu_rdy !== 1'b1 || mem[12'h302] !== 8'h6E || dcu_rdy !== 1'b0) begin
      $display("FAIL mcu_with_dcu_off got rdy=%b mem=%h dcu_rdy=%b exp 1 6e 0",
               mcu_rdy, mem[12'h302], dcu_rdy);
      n_fail++;
    end
    dcu_req = 1'b0;
    repeat (4) @(negedge CLK);
  endtask
`endif

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
    test_snes_read();
    test_snes_write();
    test_snes_during_mcu();
    test_reset_mid_access();
`ifdef PSRAM_ARB_DCU_EN
    test_back_to_back();
`else
    test_dcu_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
